bf_pair_feeder: RTL
===================

BF_PAIR_FEEDER -- requirements
Module: bf_pair_feeder

Interface
REQ-001 Parameter DATA_WIDTH, default 14: coefficient width; matches the butterfly PE u/v width.
REQ-002 Parameter LOGN, default 8: log2 of transform length N; N/2 pairs per stage, LOGN stages.
REQ-003 Parameter GAP, default 8: idle cycles inserted between stages to let the PE pipeline drain.
REQ-004 clk  in  1  single clock; all state is updated on the rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  one-cycle request to run a full transform; ignored while busy.
REQ-007 mode  in  1  sampled with start: 0 = NTT/CT order, 1 = INTT/GS order.
REQ-008 rd_en  out  1  read strobe to the dual-port coefficient RAM.
REQ-009 rd_addr_a, rd_addr_b  out  LOGN  read addresses for the u and v coefficients.
REQ-010 rd_data_a, rd_data_b  in  DATA_WIDTH  RAM read data, valid one cycle after rd_en.
REQ-011 u, v  out  DATA_WIDTH  registered butterfly operands to the PE.
REQ-012 sel  out  1  PE mode select; equals the mode latched at start.
REQ-013 pair_valid  out  1  u, v, u_idx and v_idx are valid this cycle.
REQ-014 u_idx, v_idx  out  LOGN  coefficient addresses of the current pair, for write-back alignment.
REQ-015 stage_idx  out  LOGN bits  stage number of the pair currently being issued.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 done  out  1  one-cycle completion pulse.

Function
REQ-018 The FSM SHALL have the states IDLE, ISSUE, GAPW, FLUSH and DONE.
REQ-019 A start seen in IDLE SHALL latch mode, clear stage and j, and enter ISSUE; the first rd_en occurs in the next cycle.
REQ-020 ISSUE SHALL issue one pair per cycle, j = 0..N/2-1, with rd_en=1.
REQ-021 The stride h SHALL be N/2 >> stage when mode=0, and 1 << stage when mode=1.
REQ-022 Addresses: rd_addr_a = ((j >> log2 h) << (log2 h + 1)) | (j & (h-1)), and rd_addr_b = rd_addr_a + h.
REQ-023 After pair j=N/2-1 the FSM SHALL enter GAPW for exactly GAP cycles, then return to ISSUE with stage+1 and j=0.
REQ-024 After pair j=N/2-1 of the last stage (stage=LOGN-1) the FSM SHALL enter FLUSH instead of GAPW.
REQ-025 Latency: a pair issued in cycle t SHALL appear on u/v/u_idx/v_idx with pair_valid=1 in cycle t+2.
REQ-026 FLUSH SHALL last 2 cycles; DONE lasts 1 cycle with done=1 and then returns to IDLE.
REQ-027 done SHALL therefore assert in the cycle after the final pair_valid.
REQ-028 start SHALL be ignored while busy=1; a start in the same cycle as DONE is also ignored.
REQ-029 Addresses SHALL stay within 0..N-1 with no wrap-around; j and the GAP counter wrap to 0 at stage change.
REQ-030 When rd_en=0, rd_addr_a and rd_addr_b SHALL hold their last values and pair_valid SHALL fall two cycles later.

Reset
REQ-031 rst SHALL force IDLE asynchronously at any time, including mid-run, and cancel all in-flight pairs.
REQ-032 Reset values SHALL be 0 for every output: u, v, u_idx, v_idx, rd_addr_*, stage_idx, sel, rd_en, pair_valid, busy and done.

Configuration
REQ-033 Macro BF_FEED_HOLD_EN controls a 1-bit input port hold.
REQ-034 With BF_FEED_HOLD_EN defined, hold=1 SHALL suppress rd_en and freeze j and the GAP counter in ISSUE and GAPW.
REQ-035 With BF_FEED_HOLD_EN defined, pairs already in flight SHALL still emerge during hold, and start is still accepted in IDLE.
REQ-036 Without BF_FEED_HOLD_EN, the hold port SHALL be absent and behaviour SHALL equal hold=0.

Structure
REQ-037 Package bf_feed_pkg SHALL hold the FSM state typedef and the default DATA_WIDTH, LOGN and GAP constants.
REQ-038 Address computation (j, stage, mode -> rd_addr_a, rd_addr_b) SHALL be a combinational sub-module named bf_addr_gen.

Verification (N=256, GAP=8, 1-cycle RAM model)
REQ-039 Scenario 1: mode=0 start at cycle c -> first rd_en at c+1 with addresses (0,128); next issue (1,129); stage 7 issues (0,1) then (2,3).
REQ-040 Scenario 2: mode=1 -> stage 0 issues (0,1) then (2,3); stage 7 issues (0,128) then (1,129); sel=1 throughout.
REQ-041 Scenario 3: full run -> exactly 1024 pair_valid cycles; exactly 8 idle cycles between stages; last pair_valid at c+1082; done at c+1083; busy low at c+1084.
REQ-042 Scenario 4: RAM holds data = address -> every pair_valid cycle has u=u_idx and v=v_idx.
REQ-043 Scenario 5: rst asserted at cycle c+300 -> all outputs 0 immediately, IDLE; a fresh start then restarts cleanly from (0,128).
REQ-044 Scenario 6 (BF_FEED_HOLD_EN): hold=1 for 5 cycles during stage 2 -> 5-cycle hole in rd_en, no pair skipped or duplicated, done delayed by 5 cycles; start pulses while busy have no effect.

Source files
------------

// File: rtl/bf_feed_pkg.sv
// Shared types and default sizing for the butterfly pair feeder.
// Holds the FSM state encoding and the default coefficient/transform/gap constants.
package bf_feed_pkg;

    localparam int DEF_DATA_WIDTH = 14;
    localparam int DEF_LOGN       = 8;
    localparam int DEF_GAP        = 8;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_GAPW  = 3'd2,
        S_FLUSH = 3'd3,
        S_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/bf_addr_gen.sv
// Butterfly read-address generator: pair index j, stage and order -> (u, v) addresses.
// Latency: combinational.
// Backpressure: none; the caller decides when the addresses are used.
module bf_addr_gen
    import bf_feed_pkg::*;
#(
    parameter int LOGN = DEF_LOGN
) (
    input  logic [LOGN-2:0] j,
    input  logic [LOGN-1:0] stage,
    input  logic            mode,
    output logic [LOGN-1:0] addr_a,
    output logic [LOGN-1:0] addr_b
);

    logic [LOGN-1:0] lh;
    logic [LOGN-1:0] h;
    logic [LOGN-1:0] j_ext;
    logic [LOGN-1:0] hi;

    // CT order shrinks the stride each stage, GS order grows it
    always_comb begin
        lh     = mode ? stage : (LOGN'(LOGN-1) - stage);
        h      = LOGN'(1) << lh;
        j_ext  = {1'b0, j};
        hi     = (j_ext >> lh) << (lh + LOGN'(1));
        addr_a = hi | (j_ext & (h - LOGN'(1)));
        addr_b = addr_a + h;
    end

endmodule

// File: rtl/bf_pair_feeder.sv
// Sequences N/2 butterfly pairs per stage over LOGN stages from a dual-port RAM into the PE.
// Latency: a pair issued on rd_en in cycle t appears on u/v with pair_valid in cycle t+2.
// Backpressure: none by default; with BF_FEED_HOLD_EN, hold stalls issue while in-flight pairs drain.
module bf_pair_feeder
    import bf_feed_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int LOGN       = DEF_LOGN,
    parameter int GAP        = DEF_GAP
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  mode,
`ifdef BF_FEED_HOLD_EN
    input  logic                  hold,
`endif
    output logic                  rd_en,
    output logic [LOGN-1:0]       rd_addr_a,
    output logic [LOGN-1:0]       rd_addr_b,
    input  logic [DATA_WIDTH-1:0] rd_data_a,
    input  logic [DATA_WIDTH-1:0] rd_data_b,
    output logic [DATA_WIDTH-1:0] u,
    output logic [DATA_WIDTH-1:0] v,
    output logic                  sel,
    output logic                  pair_valid,
    output logic [LOGN-1:0]       u_idx,
    output logic [LOGN-1:0]       v_idx,
    output logic [LOGN-1:0]       stage_idx,
    output logic                  busy,
    output logic                  done
);

    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    state_t          state_q, state_d;
    logic [LOGN-2:0] j_q;
    logic [LOGN-1:0] stage_q;
    logic            mode_q;
    logic [GW-1:0]   gap_q;
    logic            hold_w;
    logic            j_last, stage_last, gap_last;
    logic [LOGN-1:0] gen_a, gen_b, last_a, last_b;
    logic            s1_vld;
    logic [LOGN-1:0] s1_idx_a, s1_idx_b;

`ifdef BF_FEED_HOLD_EN
    assign hold_w = hold;
`else
    assign hold_w = 1'b0;
`endif

    assign j_last     = &j_q;
    assign stage_last = (stage_q == LOGN'(LOGN-1));
    assign gap_last   = (gap_q == GW'(GAP-1));

    bf_addr_gen #(.LOGN(LOGN)) u_addr_gen (
        .j      (j_q),
        .stage  (stage_q),
        .mode   (mode_q),
        .addr_a (gen_a),
        .addr_b (gen_b)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        rd_en   = 1'b0;
        busy    = 1'b1;
        done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                rd_en = !hold_w;
                if (!hold_w && j_last) state_d = stage_last ? S_FLUSH : S_GAPW;
            end
            S_GAPW: begin
                if (!hold_w && gap_last) state_d = S_ISSUE;
            end
            S_FLUSH: begin
                // gap_q doubles as the two-cycle drain counter here
                if (gap_q == GW'(1)) state_d = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                busy    = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            j_q     <= '0;
            stage_q <= '0;
            mode_q  <= 1'b0;
            gap_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (start) begin
                    mode_q  <= mode;
                    stage_q <= '0;
                    j_q     <= '0;
                    gap_q   <= '0;
                end
                S_ISSUE: if (!hold_w) j_q <= j_q + 1'b1;
                S_GAPW: if (!hold_w) begin
                    if (gap_last) begin
                        gap_q   <= '0;
                        stage_q <= stage_q + 1'b1;
                    end else begin
                        gap_q   <= gap_q + 1'b1;
                    end
                end
                S_FLUSH: gap_q <= gap_q + 1'b1;
                S_DONE:  gap_q <= '0;
                default: ;
            endcase
        end
    end

    // Addresses hold their last issued value whenever no read is in progress
    assign rd_addr_a = rd_en ? gen_a : last_a;
    assign rd_addr_b = rd_en ? gen_b : last_b;
    assign stage_idx = stage_q;
    assign sel       = mode_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_a     <= '0;
            last_b     <= '0;
            s1_vld     <= 1'b0;
            s1_idx_a   <= '0;
            s1_idx_b   <= '0;
            pair_valid <= 1'b0;
            u          <= '0;
            v          <= '0;
            u_idx      <= '0;
            v_idx      <= '0;
        end else begin
            if (rd_en) begin
                last_a <= gen_a;
                last_b <= gen_b;
            end
            s1_vld     <= rd_en;
            s1_idx_a   <= rd_addr_a;
            s1_idx_b   <= rd_addr_b;
            pair_valid <= s1_vld;
            if (s1_vld) begin
                u     <= rd_data_a;
                v     <= rd_data_b;
                u_idx <= s1_idx_a;
                v_idx <= s1_idx_b;
            end
        end
    end

endmodule
